// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC and issues single-outstanding word fetches.
// It holds each fetched word in the instruction register until decode consumes it.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] pc,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    output logic        fault
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        FAULT = 2'd2
    } state_t;

    state_t state;

    function automatic logic [31:0] next_seq_pc(input logic [31:0] cur);
        return cur + 32'd4;
    endfunction

    function automatic logic misaligned(input logic [31:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

    // The request must never leak out while reset is held, even mid-request.
    assign imem_req  = (state == FETCH) && !reset;
    assign imem_addr = pc;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= FETCH;
            pc          <= RESET_PC;
            instr       <= 32'h0;
            instr_pc    <= RESET_PC;
            instr_valid <= 1'b0;
            fault       <= 1'b0;
        end else begin
            case (state)
                FETCH, HOLD: begin
                    if (redirect) begin
                        // Redirect outranks both a same-cycle response and a stall.
                        instr_valid <= 1'b0;
                        if (misaligned(redirect_pc)) begin
                            fault <= 1'b1;
                            state <= FAULT;
                        end else begin
                            pc    <= redirect_pc;
                            state <= FETCH;
                        end
                    end else if (state == FETCH) begin
                        if (imem_ready) begin
                            instr       <= imem_rdata;
                            instr_pc    <= pc;
                            instr_valid <= 1'b1;
                            pc          <= next_seq_pc(pc);
                            state       <= HOLD;
                        end
                    end else if (!stall) begin
                        instr_valid <= 1'b0;
                        state       <= FETCH;
                    end
                end
                FAULT: begin
                    instr_valid <= 1'b0;
                end
                default: begin
                    instr_valid <= 1'b0;
                    state       <= FETCH;
                end
            endcase
        end
    end

endmodule
